// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the single L1-side port of the L2 cache between
// the data L1 (port 0) and the instruction L1 (port 1).
// A granted request is latched and strobed to L2 for one cycle. The arbiter
// then waits for l2_ready, bounded by a timeout, and returns the block, hit
// and error status together with a one-cycle done pulse to the owning port.
// Optional feature: define L2_ARB_RR_EN for round-robin arbitration.
// Without it, port 0 has fixed priority.
module l2_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int BLOCK_SIZE = 32,
  parameter int TIMEOUT    = 64,
  localparam int BW        = BLOCK_SIZE * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [BW-1:0]         p0_wdata,
  input  logic [BW-1:0]         p1_wdata,
  input  logic                  p0_read,
  input  logic                  p1_read,
  input  logic                  p0_write,
  input  logic                  p1_write,
  output logic                  p0_done,
  output logic                  p1_done,
  output logic [BW-1:0]         resp_rdata,
  output logic                  resp_hit,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] l2_addr,
  output logic [BW-1:0]         l2_wdata,
  output logic                  l2_read,
  output logic                  l2_write,
  input  logic [BW-1:0]         l2_rdata,
  input  logic                  l2_ready,
  input  logic                  l2_hit,
  output logic                  busy,
  output logic                  grant
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [CW-1:0]   count;
`ifdef L2_ARB_RR_EN
  logic            last_served;
`endif

  logic                  p0_req;
  logic                  p1_req;
  logic                  win;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [BW-1:0]         sel_wdata;
  logic                  timed_out;
  logic                  finish;

  // Winner selection and end-of-transaction detection.
  always_comb begin
    // NOTE: every signal driven here is assigned on every pass. No path leaves
    // a value unassigned, so no latch is inferred.
    p0_req = p0_read | p0_write;
    p1_req = p1_read | p1_write;
`ifdef L2_ARB_RR_EN
    win = (p0_req && p1_req) ? ~last_served : ~p0_req;
`else
    win = ~p0_req;
`endif
    sel_addr  = win ? p1_addr  : p0_addr;
    sel_wdata = win ? p1_wdata : p0_wdata;
    // Write takes precedence when a port raises read and write together.
    sel_write = win ? p1_write : p0_write;
    // A ready in the last allowed cycle still counts as a normal completion.
    timed_out = (state == WAIT) && !l2_ready && (count >= CW'(TIMEOUT));
    finish    = ((state == ISSUE) || (state == WAIT)) && (l2_ready || timed_out);
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      p0_done    <= 1'b0;
      p1_done    <= 1'b0;
      resp_rdata <= '0;
      resp_hit   <= 1'b0;
      resp_err   <= 1'b0;
      l2_addr    <= '0;
      l2_wdata   <= '0;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      busy       <= 1'b0;
      grant      <= 1'b0;
`ifdef L2_ARB_RR_EN
      last_served <= 1'b1;
`endif
    end else begin
      // NOTE: state registers use nonblocking assignments. Every read in this
      // block therefore sees the value from before the edge.
      p0_done  <= 1'b0;
      p1_done  <= 1'b0;
      l2_read  <= 1'b0;
      l2_write <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            grant    <= win;
            l2_addr  <= sel_addr;
            l2_wdata <= sel_wdata;
            l2_write <= sel_write;
            l2_read  <= ~sel_write;
            busy     <= 1'b1;
            count    <= CW'(1);
            state    <= ISSUE;
`ifdef L2_ARB_RR_EN
            last_served <= win;
`endif
          end
        end
        ISSUE, WAIT: begin
          if (finish) begin
            resp_rdata <= timed_out ? '0 : l2_rdata;
            resp_hit   <= ~timed_out & l2_hit;
            resp_err   <= timed_out;
            p0_done    <= ~grant;
            p1_done    <= grant;
            state      <= RESP;
          end else begin
            state <= WAIT;
            if (count < CW'(TIMEOUT)) count <= count + 1'b1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: table-driven vectors and a response scoreboard for
// l2_port_arbiter. Hand-written sequences cover reset during a transaction
// and back-to-back arbitration between the two ports.
module tb_l2_port_arbiter;

  localparam int DW      = 32;
  localparam int AW      = 11;
  localparam int BS      = 32;
  localparam int BW      = BS * DW;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [BW-1:0] p0_wdata, p1_wdata;
  logic          p0_read, p1_read, p0_write, p1_write;
  logic          p0_done, p1_done;
  logic [BW-1:0] resp_rdata;
  logic          resp_hit, resp_err;
  logic [AW-1:0] l2_addr;
  logic [BW-1:0] l2_wdata;
  logic          l2_read, l2_write;
  logic [BW-1:0] l2_rdata;
  logic          l2_ready, l2_hit;
  logic          busy, grant;

  int compared = 0;
  int failed   = 0;

  l2_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_read(p0_read), .p1_read(p1_read),
    .p0_write(p0_write), .p1_write(p1_write),
    .p0_done(p0_done), .p1_done(p1_done),
    .resp_rdata(resp_rdata), .resp_hit(resp_hit), .resp_err(resp_err),
    .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_read(l2_read), .l2_write(l2_write),
    .l2_rdata(l2_rdata), .l2_ready(l2_ready), .l2_hit(l2_hit),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected completion, queued when a request is driven.
  typedef struct {
    bit            port;
    bit            write;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    int            lat;
    bit            err;
    bit            hit;
    logic [BW-1:0] rdata;
  } exp_t;

  exp_t sb[$];

  // One table row: request stimulus, L2 behaviour and expected outcome.
  typedef struct {
    bit            port;
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [31:0]   wseed;
    int            delay;     // ready in this WAIT cycle (0 = in ISSUE, -1 = never)
    bit            hit;
    logic [31:0]   base;
    int            exp_lat;   // cycles from sampling edge to done
    bit            exp_err;
    bit            exp_write;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [BW-1:0] mk_block(input logic [31:0] seed);
    logic [BW-1:0] b;
    for (int i = 0; i < BS; i++) b[i*DW +: DW] = seed ^ 32'(i);
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_blk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    compared++;
    if (act !== exp) begin
      int first;
      first = 0;
      for (int i = BS - 1; i >= 0; i--)
        if (act[i*DW +: DW] !== exp[i*DW +: DW]) first = i;
      failed++;
      $display("FAIL %s word %0d: got 0x%h expected 0x%h", name, first,
               act[first*DW +: DW], exp[first*DW +: DW]);
    end
  endtask

  task automatic set_req(input bit port, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [BW-1:0] d);
    if (!port) begin
      p0_read = rd; p0_write = wr; p0_addr = a; p0_wdata = d;
    end else begin
      p1_read = rd; p1_write = wr; p1_addr = a; p1_wdata = d;
    end
  endtask

  // Entered at a negedge with the DUT idle and the request(s) already driven.
  // Plays the L2 side, checks the strobe, and compares the completion against
  // the scoreboard.
  task automatic serve(input bit port, input bit wr, input logic [AW-1:0] addr,
                       input logic [BW-1:0] wdata, input int delay, input bit hit,
                       input logic [31:0] base, input int exp_lat, input bit exp_err);
    exp_t e;
    int   strobes;
    bit   seen;
    e.port  = port;
    e.write = wr;
    e.addr  = addr;
    e.wdata = wdata;
    e.lat   = exp_lat;
    e.err   = exp_err;
    e.hit   = exp_err ? 1'b0 : hit;
    e.rdata = exp_err ? '0 : mk_block(base);
    sb.push_back(e);
    strobes = 0;
    seen    = 1'b0;
    @(posedge clk);
    for (int cyc = 1; cyc <= TIMEOUT + 8 && !seen; cyc++) begin
      @(negedge clk);
      l2_ready = 1'b0;
      l2_hit   = 1'b0;
      l2_rdata = '1;
      if (l2_read || l2_write) begin
        strobes++;
        if (strobes == 1) begin
          check("strobe_cycle", 64'(cyc), 64'd1);
          check("l2_write", l2_write, e.write);
          check("l2_read", l2_read, !e.write);
          check("l2_addr", l2_addr, e.addr);
          check_blk("l2_wdata", l2_wdata, e.wdata);
          check("grant", grant, e.port);
          check("busy_active", busy, 1'b1);
        end
      end
      if (p0_done || p1_done) begin
        exp_t x;
        seen = 1'b1;
        x = sb.pop_front();
        check("p0_done", p0_done, x.port == 1'b0);
        check("p1_done", p1_done, x.port == 1'b1);
        check("done_latency", 64'(cyc), 64'(x.lat));
        check_blk("resp_rdata", resp_rdata, x.rdata);
        check("resp_hit", resp_hit, x.hit);
        check("resp_err", resp_err, x.err);
        check("l2_addr_held", l2_addr, x.addr);
        set_req(x.port, 1'b0, 1'b0, '0, '0);
      end else if (cyc == delay + 1) begin
        l2_ready = 1'b1;
        l2_hit   = hit;
        l2_rdata = mk_block(base);
      end
    end
    if (!seen) begin
      compared++;
      failed++;
      $display("FAIL done_wait: no done pulse within %0d cycles", TIMEOUT + 8);
      void'(sb.pop_front());
      set_req(port, 1'b0, 1'b0, '0, '0);
    end
    check("strobe_count", 64'(strobes), 64'd1);
    @(negedge clk);
    check("done_cleared", {p0_done, p1_done}, 2'b00);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    bit [1:0] rem0, rem1;
    bit       last, pick;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 11'h00A, 32'h0,        0, 1'b1, 32'hDEADBEEF, 2,           1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 11'h014, 32'hA5A5A5A5, 3, 1'b1, 32'h12345678, 5,           1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 11'h7FF, 32'h5A5A0000, 1, 1'b0, 32'hCAFEF00D, 3,           1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 11'h000, 32'h0,        2, 1'b1, 32'h0BADC0DE, 4,           1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 11'h123, 32'h0,       -1, 1'b1, 32'hFFFF0000, TIMEOUT + 1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 11'h3C0, 32'h0,        0, 1'b0, 32'h13579BDF, 2,           1'b0, 1'b0};

    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    l2_ready = 1'b0;
    l2_hit   = 1'b0;
    l2_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", {p0_done, p1_done}, 2'b00);
    check("rst_strobes", {l2_read, l2_write}, 2'b00);
    check("rst_status", {resp_hit, resp_err, busy, grant}, 4'b0000);
    check("rst_l2_addr", l2_addr, 11'h0);
    check_blk("rst_l2_wdata", l2_wdata, '0);
    check_blk("rst_resp_rdata", resp_rdata, '0);
    rst = 1'b0;

    // Table-driven single transactions.
    for (int v = 0; v < 6; v++) begin
      set_req(vecs[v].port, vecs[v].rd, vecs[v].wr, vecs[v].addr, mk_block(vecs[v].wseed));
      serve(vecs[v].port, vecs[v].exp_write, vecs[v].addr, mk_block(vecs[v].wseed),
            vecs[v].delay, vecs[v].hit, vecs[v].base, vecs[v].exp_lat, vecs[v].exp_err);
    end

    // Reset during WAIT: the transaction is abandoned with no done pulse, and
    // a late ready in IDLE is ignored.
    set_req(1'b0, 1'b1, 1'b0, 11'h055, mk_block(32'h77770000));
    @(posedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_done", {p0_done, p1_done}, 2'b00);
    check("midrst_status", {l2_read, l2_write, resp_hit, resp_err, busy, grant}, 6'b0);
    check("midrst_l2_addr", l2_addr, 11'h0);
    check_blk("midrst_l2_wdata", l2_wdata, '0);
    check_blk("midrst_resp_rdata", resp_rdata, '0);
    rst = 1'b0;
    l2_ready = 1'b1;
    l2_hit   = 1'b1;
    l2_rdata = mk_block(32'h99990000);
    repeat (3) begin
      @(negedge clk);
      check("late_ready_ignored", {p0_done, p1_done, busy, resp_hit, l2_read}, 5'b0);
    end
    l2_ready = 1'b0;
    l2_hit   = 1'b0;
    @(negedge clk);

    // Both ports hold read requests and each re-requests once after its done.
    rem0 = 2;
    rem1 = 2;
    last = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 11'h100, mk_block(32'h11110000));
    set_req(1'b1, 1'b1, 1'b0, 11'h200, mk_block(32'h22220000));
    for (int k = 0; k < 4; k++) begin
`ifdef L2_ARB_RR_EN
      if (rem0 != 0 && rem1 != 0) pick = ~last;
      else                        pick = (rem0 != 0) ? 1'b0 : 1'b1;
      last = pick;
`else
      pick = (rem0 != 0) ? 1'b0 : 1'b1;
`endif
      serve(pick, 1'b0, pick ? 11'h200 : 11'h100,
            mk_block(pick ? 32'h22220000 : 32'h11110000),
            k, 1'b1, 32'hC0DE0000 + 32'(k), k + 2, 1'b0);
      if (!pick) begin
        rem0--;
        if (rem0 != 0) set_req(1'b0, 1'b1, 1'b0, 11'h100, mk_block(32'h11110000));
      end else begin
        rem1--;
        if (rem1 != 0) set_req(1'b1, 1'b1, 1'b0, 11'h200, mk_block(32'h22220000));
      end
    end
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
